interboard_link: RTL and testbench
==================================

# interboard_link

Parametrised board-to-board link transceiver for the Bingo design. It replaces the fixed 6-bit request/ack exchange between master and slave boards. Game logic hands it whole messages of MSG_W bits through a valid/ready port. The block queues them in a TX FIFO, splits each into DATA_W-bit words, and sends every word with a four-phase Request/Ack handshake. In the other direction it synchronises incoming Request_in, reassembles received words, and presents complete messages as a one-cycle pulse. It adds acknowledge timeout and receive-side resynchronisation.

## Interface
- DATA_W, 6, width of inter_data_in/out wires
- MSG_W, 8, message width (default: 3-bit msg_type in [7:5], 5-bit number in [4:0])
- FIFO_DEPTH, 4, TX message queue depth, power of two ≥2
- SYNC_STAGES, 2, flip-flop stages on Request_in/Ack_in, ≥2
- TIMEOUT, 1024, cycles allowed per handshake phase / between RX words
- clk  in  1  system clock; single clock domain
- rst  in  1  asynchronous, active-high reset
- tx_valid  in  1  message offered
- tx_msg  in  MSG_W  message to send
- tx_ready  out  1  FIFO can accept (count < FIFO_DEPTH)
- tx_count  out  clog2(FIFO_DEPTH)+1  messages queued, including the one in flight
- tx_timeout  out  1  one-cycle pulse when a message is abandoned
- rx_valid  out  1  one-cycle pulse, rx_msg valid
- rx_msg  out  MSG_W  last received message, held until the next one
- Request_in, Ack_in  in  1  remote handshake lines (asynchronous)
- inter_data_in  in  DATA_W  remote data
- Request_out, Ack_out  out  1  local handshake lines, registered
- inter_data_out  out  DATA_W  local data, registered

## Operation
- NWORDS = ceil(MSG_W/DATA_W). Word k = tx_msg[k*DATA_W +: DATA_W]. Word 0 is sent first. Bits above MSG_W in the last word are sent as 0.
- FIFO push: on tx_valid && tx_ready. The head is popped when its last word completes or when it times out. Pushes are gated by the registered count only, so a full FIFO refuses a push even in the cycle it pops.
- TX FSM:
  - IDLE: if FIFO is non-empty, load word 0 onto inter_data_out and go to SETUP.
  - SETUP: one cycle of data setup, then Request_out←1 and go to WAIT_HI.
  - WAIT_HI: when synced Ack_in=1, Request_out←0 and go to WAIT_LO.
  - WAIT_LO: when synced Ack_in=0:
    - last word: pop the message and go to IDLE;
    - otherwise: load the next word and go to SETUP.
- TX timeout: a phase timer is cleared on every state entry. If it reaches TIMEOUT in WAIT_HI or WAIT_LO:
  - Request_out←0;
  - pulse tx_timeout;
  - pop (discard) the message;
  - go to IDLE. The next message waits until synced Ack_in=0.
- RX FSM:
  - R_IDLE: on synced Request_in=1, capture inter_data_in into word slot rx_idx, set Ack_out←1, go to R_ACK.
  - R_ACK: on synced Request_in=0, set Ack_out←0. If rx_idx=NWORDS-1, update rx_msg, pulse rx_valid, rx_idx←0; otherwise rx_idx+1. Return to R_IDLE.
  - Data is captured only after the synchronised request. The sender's SETUP cycle plus the sync latency guarantees data stability.
- RX resync: if rx_idx≠0 and no new request arrives within TIMEOUT cycles of the last word, rx_idx←0 and the partial data is dropped with no pulse.
- There is no RX backpressure. The consumer must accept rx_valid on the cycle it pulses.
- TX and RX are independent; full-duplex operation is legal.

## Timing
- Reset values: Request_out=0, Ack_out=0, inter_data_out=0, tx_ready=1, tx_count=0, tx_timeout=0, rx_valid=0, rx_msg=0. Both FSMs idle, FIFO empty, rx_idx=0.
- Reset mid-transfer: everything returns to reset values immediately (asynchronous), and the FIFO contents are lost.
- First transmission after a push into an empty FIFO:
  - push at cycle 0;
  - data driven at cycle 1;
  - Request_out high at cycle 2.
- Per word, the minimum is 2·SYNC_STAGES round-trip latency plus 2 cycles on each side.
- rx_valid asserts the cycle after synced Request_in falls for the last word.
- tx_count updates the cycle after a push or pop. A simultaneous push and pop leaves it unchanged.

## Test plan
- Loopback of two instances, defaults. Push 8'hA5. Required:
  - words 6'h25 then 6'h02 on the wire;
  - exactly one rx_valid on the receiver;
  - rx_msg=8'hA5.
- Hold Ack_in=0 with TIMEOUT=16. Push 5 messages. Required:
  - tx_ready falls after the 4th push and the 5th is refused;
  - tx_count=4;
  - Request_out stays high 16 cycles, then falls;
  - tx_timeout pulses once and tx_count becomes 3.
- Back-to-back loopback with 0x00, 0xFF, 0x3C pushed on consecutive cycles. Required: rx_msg sequence is identical with exactly three rx_valid pulses.
- RX resync: drive one word, then no further request for TIMEOUT+5 cycles, then a full 2-word 8'h81. Required: rx_msg=8'h81 with no earlier pulse.
- Assert rst while in WAIT_HI. Required:
  - Request_out=0 and tx_count=0 without waiting for a clock edge;
  - normal transfer works after release.
- DATA_W=8, MSG_W=8, full-duplex loopback. Required:
  - single-word messages;
  - both directions deliver 8'h5A and 8'hC3 concurrently.

Source files
------------

// File: rtl/interboard_link.sv
// Board-to-board message link: TX FIFO feeding a word-serialised four-phase
// Request/Ack handshake, and RX word reassembly with ack timeout and resync.
module interboard_link #(
    parameter int unsigned DATA_W      = 6,
    parameter int unsigned MSG_W       = 8,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tx_valid,
    input  logic [MSG_W-1:0]            tx_msg,
    output logic                        tx_ready,
    output logic [$clog2(FIFO_DEPTH):0] tx_count,
    output logic                        tx_timeout,
    output logic                        rx_valid,
    output logic [MSG_W-1:0]            rx_msg,
    input  logic                        Request_in,
    input  logic                        Ack_in,
    input  logic [DATA_W-1:0]           inter_data_in,
    output logic                        Request_out,
    output logic                        Ack_out,
    output logic [DATA_W-1:0]           inter_data_out
);
    localparam int unsigned NWORDS = (MSG_W + DATA_W - 1) / DATA_W;
    localparam int unsigned PAD_W  = NWORDS * DATA_W;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int unsigned TMR_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {T_IDLE, T_SETUP, T_WAIT_HI, T_WAIT_LO} tx_state_t;
    typedef enum logic {R_IDLE, R_ACK} rx_state_t;

    logic [SYNC_STAGES-1:0] r_req_sync, r_ack_sync;
    logic                   w_req_s, w_ack_s;

    logic [MSG_W-1:0]  r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]  r_count, w_cnt_nxt;
    logic              r_tx_ready, w_push, w_pop;

    tx_state_t         r_tx_state, w_tx_state_nxt;
    logic              r_req, w_req_nxt, r_tx_to, w_to_nxt;
    logic [DATA_W-1:0] r_data, w_data_nxt, w_word0, w_word_next;
    logic [IDX_W-1:0]  r_widx, w_widx_nxt, w_widx_inc;
    logic [TMR_W-1:0]  r_ttmr;
    logic              w_ttmr_exp, w_tx_last;
    logic [PAD_W-1:0]  w_msg_pad;

    rx_state_t         r_rx_state, w_rx_state_nxt;
    logic              r_ack, w_ack_nxt, r_rx_valid, w_rx_cap, w_rx_done;
    logic [IDX_W-1:0]  r_rx_idx, w_ridx_nxt;
    logic [TMR_W-1:0]  r_rtmr;
    logic              w_rtmr_exp, w_rx_last;
    logic [DATA_W-1:0] r_rx_buf [NWORDS];
    logic [PAD_W-1:0]  w_rx_pad;
    logic [MSG_W-1:0]  r_rx_msg;

    // Remote handshake synchronisers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_sync <= '0;
            r_ack_sync <= '0;
        end else begin
            r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], Request_in};
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], Ack_in};
        end
    end
    assign w_req_s = r_req_sync[SYNC_STAGES-1];
    assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

    // TX message queue; acceptance depends only on the registered count
    assign w_push = tx_valid && r_tx_ready;

    always_comb begin
        w_cnt_nxt = r_count;
        if (w_push && !w_pop)
            w_cnt_nxt = r_count + CNT_W'(1);
        else if (!w_push && w_pop)
            w_cnt_nxt = r_count - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo[r_wr_ptr] <= tx_msg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_tx_ready <= 1'b1;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count    <= w_cnt_nxt;
            r_tx_ready <= (w_cnt_nxt < CNT_W'(FIFO_DEPTH));
        end
    end

    // Word slicing of the queue head; bits above MSG_W go out as zero
    assign w_widx_inc = r_widx + IDX_W'(1);
    always_comb begin
        w_msg_pad   = PAD_W'(r_fifo[r_rd_ptr]);
        w_word0     = w_msg_pad[DATA_W-1:0];
        w_word_next = '0;
        for (int unsigned k = 0; k < NWORDS; k++)
            if (IDX_W'(k) == w_widx_inc)
                w_word_next = w_msg_pad[k*DATA_W +: DATA_W];
    end

    assign w_ttmr_exp = (r_ttmr == TMR_W'(TIMEOUT - 1));
    assign w_tx_last  = (r_widx == IDX_W'(NWORDS - 1));

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_req_nxt      = r_req;
        w_data_nxt     = r_data;
        w_widx_nxt     = r_widx;
        w_pop          = 1'b0;
        w_to_nxt       = 1'b0;
        case (r_tx_state)
            T_IDLE: begin
                // Remote ack must be low before a new message starts
                if (r_count != '0 && !w_ack_s) begin
                    w_widx_nxt     = '0;
                    w_data_nxt     = w_word0;
                    w_tx_state_nxt = T_SETUP;
                end
            end
            T_SETUP: begin
                w_req_nxt      = 1'b1;
                w_tx_state_nxt = T_WAIT_HI;
            end
            T_WAIT_HI: begin
                if (w_ack_s) begin
                    w_req_nxt      = 1'b0;
                    w_tx_state_nxt = T_WAIT_LO;
                end else if (w_ttmr_exp) begin
                    w_req_nxt      = 1'b0;
                    w_pop          = 1'b1;
                    w_to_nxt       = 1'b1;
                    w_tx_state_nxt = T_IDLE;
                end
            end
            T_WAIT_LO: begin
                if (!w_ack_s) begin
                    if (w_tx_last) begin
                        w_pop          = 1'b1;
                        w_tx_state_nxt = T_IDLE;
                    end else begin
                        w_widx_nxt     = w_widx_inc;
                        w_data_nxt     = w_word_next;
                        w_tx_state_nxt = T_SETUP;
                    end
                end else if (w_ttmr_exp) begin
                    w_pop          = 1'b1;
                    w_to_nxt       = 1'b1;
                    w_tx_state_nxt = T_IDLE;
                end
            end
            default: w_tx_state_nxt = T_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state <= T_IDLE;
            r_req      <= 1'b0;
            r_data     <= '0;
            r_widx     <= '0;
            r_ttmr     <= '0;
            r_tx_to    <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_req      <= w_req_nxt;
            r_data     <= w_data_nxt;
            r_widx     <= w_widx_nxt;
            r_tx_to    <= w_to_nxt;
            if (w_tx_state_nxt != r_tx_state)
                r_ttmr <= '0;
            else if (!w_ttmr_exp)
                r_ttmr <= r_ttmr + TMR_W'(1);
        end
    end

    // RX: capture on synced request, complete message on its release
    assign w_rtmr_exp = (r_rtmr == TMR_W'(TIMEOUT - 1));
    assign w_rx_last  = (r_rx_idx == IDX_W'(NWORDS - 1));

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_ack_nxt      = r_ack;
        w_ridx_nxt     = r_rx_idx;
        w_rx_cap       = 1'b0;
        w_rx_done      = 1'b0;
        case (r_rx_state)
            R_IDLE: begin
                if (w_req_s) begin
                    w_rx_cap       = 1'b1;
                    w_ack_nxt      = 1'b1;
                    w_rx_state_nxt = R_ACK;
                end else if (r_rx_idx != '0 && w_rtmr_exp) begin
                    w_ridx_nxt = '0;
                end
            end
            R_ACK: begin
                if (!w_req_s) begin
                    w_ack_nxt      = 1'b0;
                    w_rx_state_nxt = R_IDLE;
                    if (w_rx_last) begin
                        w_rx_done  = 1'b1;
                        w_ridx_nxt = '0;
                    end else begin
                        w_ridx_nxt = r_rx_idx + IDX_W'(1);
                    end
                end
            end
            default: w_rx_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < NWORDS; k++)
            if (w_rx_cap && r_rx_idx == IDX_W'(k))
                r_rx_buf[k] <= inter_data_in;
    end

    always_comb begin
        w_rx_pad = '0;
        for (int unsigned k = 0; k < NWORDS; k++)
            w_rx_pad[k*DATA_W +: DATA_W] = r_rx_buf[k];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_state <= R_IDLE;
            r_ack      <= 1'b0;
            r_rx_idx   <= '0;
            r_rtmr     <= '0;
            r_rx_valid <= 1'b0;
            r_rx_msg   <= '0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_ack      <= w_ack_nxt;
            r_rx_idx   <= w_ridx_nxt;
            r_rx_valid <= w_rx_done;
            if (w_rx_done)
                r_rx_msg <= MSG_W'(w_rx_pad);
            if (w_rx_state_nxt != r_rx_state)
                r_rtmr <= '0;
            else if (!w_rtmr_exp)
                r_rtmr <= r_rtmr + TMR_W'(1);
        end
    end

    assign tx_ready       = r_tx_ready;
    assign tx_count       = r_count;
    assign tx_timeout     = r_tx_to;
    assign rx_valid       = r_rx_valid;
    assign rx_msg         = r_rx_msg;
    assign Request_out    = r_req;
    assign Ack_out        = r_ack;
    assign inter_data_out = r_data;
endmodule

// File: tb/tb_interboard_link.sv
// Bench for interboard_link: 6-bit loopback pair (a->b, with manual override of
// the handshake lines) and an 8-bit full-duplex pair (c<->d).
module tb_interboard_link;
    localparam int unsigned TO_AB = 16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_tx_valid, a_tx_ready, a_tx_timeout, a_rx_valid;
    logic [7:0] a_tx_msg, a_rx_msg;
    logic [2:0] a_tx_count;
    logic       a_req_in, a_ack_in, a_req_out, a_ack_out;
    logic [5:0] a_data_in, a_data_out;
    logic       b_tx_valid, b_tx_ready, b_tx_timeout, b_rx_valid;
    logic [7:0] b_tx_msg, b_rx_msg;
    logic [2:0] b_tx_count;
    logic       b_req_in, b_ack_in, b_req_out, b_ack_out;
    logic [5:0] b_data_in, b_data_out;
    logic       manual, tb_req_b;
    logic [5:0] tb_data_b;

    logic       c_tx_valid, c_tx_ready, c_tx_timeout, c_rx_valid;
    logic [7:0] c_tx_msg, c_rx_msg, c_data_out, d_data_out;
    logic [2:0] c_tx_count;
    logic       c_req_out, c_ack_out;
    logic       d_tx_valid, d_tx_ready, d_tx_timeout, d_rx_valid;
    logic [7:0] d_tx_msg, d_rx_msg;
    logic [2:0] d_tx_count;
    logic       d_req_out, d_ack_out;

    assign a_ack_in  = manual ? 1'b0 : b_ack_out;
    assign a_req_in  = b_req_out;
    assign a_data_in = b_data_out;
    assign b_req_in  = manual ? tb_req_b : a_req_out;
    assign b_data_in = manual ? tb_data_b : a_data_out;
    assign b_ack_in  = a_ack_out;

    interboard_link #(.DATA_W(6), .MSG_W(8), .TIMEOUT(TO_AB)) u_a (
        .clk(clk), .rst(rst), .tx_valid(a_tx_valid), .tx_msg(a_tx_msg),
        .tx_ready(a_tx_ready), .tx_count(a_tx_count), .tx_timeout(a_tx_timeout),
        .rx_valid(a_rx_valid), .rx_msg(a_rx_msg), .Request_in(a_req_in),
        .Ack_in(a_ack_in), .inter_data_in(a_data_in), .Request_out(a_req_out),
        .Ack_out(a_ack_out), .inter_data_out(a_data_out));

    interboard_link #(.DATA_W(6), .MSG_W(8), .TIMEOUT(TO_AB)) u_b (
        .clk(clk), .rst(rst), .tx_valid(b_tx_valid), .tx_msg(b_tx_msg),
        .tx_ready(b_tx_ready), .tx_count(b_tx_count), .tx_timeout(b_tx_timeout),
        .rx_valid(b_rx_valid), .rx_msg(b_rx_msg), .Request_in(b_req_in),
        .Ack_in(b_ack_in), .inter_data_in(b_data_in), .Request_out(b_req_out),
        .Ack_out(b_ack_out), .inter_data_out(b_data_out));

    interboard_link #(.DATA_W(8), .MSG_W(8)) u_c (
        .clk(clk), .rst(rst), .tx_valid(c_tx_valid), .tx_msg(c_tx_msg),
        .tx_ready(c_tx_ready), .tx_count(c_tx_count), .tx_timeout(c_tx_timeout),
        .rx_valid(c_rx_valid), .rx_msg(c_rx_msg), .Request_in(d_req_out),
        .Ack_in(d_ack_out), .inter_data_in(d_data_out), .Request_out(c_req_out),
        .Ack_out(c_ack_out), .inter_data_out(c_data_out));

    interboard_link #(.DATA_W(8), .MSG_W(8)) u_d (
        .clk(clk), .rst(rst), .tx_valid(d_tx_valid), .tx_msg(d_tx_msg),
        .tx_ready(d_tx_ready), .tx_count(d_tx_count), .tx_timeout(d_tx_timeout),
        .rx_valid(d_rx_valid), .rx_msg(d_rx_msg), .Request_in(c_req_out),
        .Ack_in(c_ack_out), .inter_data_in(c_data_out), .Request_out(d_req_out),
        .Ack_out(d_ack_out), .inter_data_out(d_data_out));

    // Passive monitors, sampling pre-edge values at the rising edge
    logic [7:0] b_rx_q[$], c_rx_q[$], d_rx_q[$];
    logic [5:0] wire_q[$];
    logic       a_req_prev, c_req_prev, d_req_prev;
    int         hi_run, last_hi_len, falls, to_pulses, c_words, d_words;
    initial begin
        a_req_prev = 0; c_req_prev = 0; d_req_prev = 0;
        hi_run = 0; last_hi_len = 0; falls = 0; to_pulses = 0; c_words = 0; d_words = 0;
    end
    always @(posedge clk) begin
        if (b_rx_valid) b_rx_q.push_back(b_rx_msg);
        if (c_rx_valid) c_rx_q.push_back(c_rx_msg);
        if (d_rx_valid) d_rx_q.push_back(d_rx_msg);
        if (a_req_out && !a_req_prev) wire_q.push_back(a_data_out);
        if (c_req_out && !c_req_prev) c_words++;
        if (d_req_out && !d_req_prev) d_words++;
        a_req_prev = a_req_out;
        c_req_prev = c_req_out;
        d_req_prev = d_req_out;
        if (a_req_out) hi_run++;
        else if (hi_run != 0) begin
            last_hi_len = hi_run;
            hi_run = 0;
            falls++;
        end
        if (a_tx_timeout) to_pulses++;
    end

    // Reference: word k of a message is its value divided by 64^k, modulo 64
    function automatic logic [5:0] word6(input logic [7:0] m, input int k);
        int v;
        v = int'(m);
        for (int i = 0; i < k; i++) v = v / 64;
        return 6'(v % 64);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (a_req_out !== 1'b0) begin errors++; $display("FAIL reset_req got %0h exp 0", a_req_out); end
        checks++; if (a_ack_out !== 1'b0) begin errors++; $display("FAIL reset_ack got %0h exp 0", a_ack_out); end
        checks++; if (a_data_out !== 6'h00) begin errors++; $display("FAIL reset_data got %0h exp 0", a_data_out); end
        checks++; if (a_tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0h exp 1", a_tx_ready); end
        checks++; if (a_tx_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", a_tx_count); end
        checks++; if (a_tx_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %0h exp 0", a_tx_timeout); end
        checks++; if (b_rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rxv got %0h exp 0", b_rx_valid); end
        checks++; if (b_rx_msg !== 8'h00) begin errors++; $display("FAIL reset_rxmsg got %0h exp 0", b_rx_msg); end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_loopback();
        int wb, rb;
        logic [7:0] m;
        logic [5:0] w;
        m = 8'hA5;
        wb = wire_q.size();
        rb = b_rx_q.size();
        @(negedge clk); a_tx_valid = 1'b1; a_tx_msg = m;
        @(negedge clk); a_tx_valid = 1'b0;
        checks++; if (a_tx_count !== 3'd1) begin errors++; $display("FAIL lb_count got %0d exp 1", a_tx_count); end
        checks++; if (a_req_out !== 1'b0) begin errors++; $display("FAIL lb_req_c0 got %0h exp 0", a_req_out); end
        @(negedge clk);
        checks++; if (a_data_out !== word6(m, 0)) begin errors++; $display("FAIL lb_data_c1 got %0h exp %0h", a_data_out, word6(m, 0)); end
        checks++; if (a_req_out !== 1'b0) begin errors++; $display("FAIL lb_req_c1 got %0h exp 0", a_req_out); end
        @(negedge clk);
        checks++; if (a_req_out !== 1'b1) begin errors++; $display("FAIL lb_req_c2 got %0h exp 1", a_req_out); end
        for (int i = 0; i < 300 && b_rx_q.size() < rb + 1; i++) @(negedge clk);
        repeat (40) @(negedge clk);
        checks++; if (wire_q.size() - wb !== 2) begin errors++; $display("FAIL lb_nwords got %0d exp 2", wire_q.size() - wb); end
        for (int k = 0; k < 2; k++) begin
            w = (wire_q.size() > wb + k) ? wire_q[wb + k] : 6'bx;
            checks++; if (w !== word6(m, k)) begin errors++; $display("FAIL lb_word%0d got %0h exp %0h", k, w, word6(m, k)); end
        end
        checks++; if (b_rx_q.size() - rb !== 1) begin errors++; $display("FAIL lb_pulses got %0d exp 1", b_rx_q.size() - rb); end
        checks++; if (b_rx_msg !== m) begin errors++; $display("FAIL lb_rxmsg got %0h exp %0h", b_rx_msg, m); end
    endtask

    task automatic test_timeout();
        int fb, tb0, accepted;
        logic exp_ready;
        manual = 1'b1; tb_req_b = 1'b0;
        repeat (4) @(negedge clk);
        fb = falls; tb0 = to_pulses; accepted = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            exp_ready = (accepted < 4);
            checks++; if (a_tx_ready !== exp_ready) begin errors++; $display("FAIL to_ready%0d got %0h exp %0h", i, a_tx_ready, exp_ready); end
            a_tx_valid = 1'b1; a_tx_msg = 8'($urandom);
            if (exp_ready) accepted++;
        end
        @(negedge clk); a_tx_valid = 1'b0;
        checks++; if (a_tx_count !== 3'(accepted)) begin errors++; $display("FAIL to_count_full got %0d exp %0d", a_tx_count, accepted); end
        for (int i = 0; i < 100 && falls == fb; i++) @(negedge clk);
        checks++; if (falls == fb) begin errors++; $display("FAIL to_req_fall got none exp a fall"); end
        checks++; if (last_hi_len !== int'(TO_AB)) begin errors++; $display("FAIL to_req_len got %0d exp %0d", last_hi_len, TO_AB); end
        checks++; if (to_pulses - tb0 !== 1) begin errors++; $display("FAIL to_pulses got %0d exp 1", to_pulses - tb0); end
        checks++; if (a_tx_count !== 3'(accepted - 1)) begin errors++; $display("FAIL to_count_pop got %0d exp %0d", a_tx_count, accepted - 1); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; manual = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic drive_word(input logic [5:0] d);
        int n;
        tb_data_b = d;
        @(negedge clk); tb_req_b = 1'b1;
        n = 0;
        while (b_ack_out !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        checks++; if (b_ack_out !== 1'b1) begin errors++; $display("FAIL drv_ack_hi got %0h exp 1", b_ack_out); end
        tb_req_b = 1'b0;
        n = 0;
        while (b_ack_out !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        checks++; if (b_ack_out !== 1'b0) begin errors++; $display("FAIL drv_ack_lo got %0h exp 0", b_ack_out); end
    endtask

    task automatic test_resync();
        int rb;
        logic [7:0] m, got;
        m = 8'h81;
        manual = 1'b1; tb_req_b = 1'b0; tb_data_b = '0;
        rb = b_rx_q.size();
        drive_word(6'($urandom));
        repeat (TO_AB + 5) @(negedge clk);
        drive_word(word6(m, 0));
        drive_word(word6(m, 1));
        repeat (5) @(negedge clk);
        got = (b_rx_q.size() > rb) ? b_rx_q[rb] : 8'bx;
        checks++; if (b_rx_q.size() - rb !== 1) begin errors++; $display("FAIL rs_pulses got %0d exp 1", b_rx_q.size() - rb); end
        checks++; if (got !== m) begin errors++; $display("FAIL rs_msg got %0h exp %0h", got, m); end
        manual = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic run_msgs(input string tag, input logic [7:0] msgs[$], input bit gaps);
        int rb, wb, k;
        logic [7:0] got;
        logic [5:0] w;
        rb = b_rx_q.size(); wb = wire_q.size(); k = 0;
        while (k < msgs.size()) begin
            @(negedge clk);
            a_tx_valid = 1'b0;
            if (a_tx_ready) begin
                a_tx_valid = 1'b1; a_tx_msg = msgs[k]; k++;
                if (gaps) begin
                    @(negedge clk); a_tx_valid = 1'b0;
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
            end
        end
        @(negedge clk); a_tx_valid = 1'b0;
        for (int i = 0; i < 2000 && b_rx_q.size() < rb + msgs.size(); i++) @(negedge clk);
        repeat (40) @(negedge clk);
        checks++; if (b_rx_q.size() - rb !== msgs.size()) begin errors++; $display("FAIL %s_pulses got %0d exp %0d", tag, b_rx_q.size() - rb, msgs.size()); end
        checks++; if (wire_q.size() - wb !== 2 * msgs.size()) begin errors++; $display("FAIL %s_nwords got %0d exp %0d", tag, wire_q.size() - wb, 2 * msgs.size()); end
        for (int i = 0; i < msgs.size(); i++) begin
            got = (b_rx_q.size() > rb + i) ? b_rx_q[rb + i] : 8'bx;
            checks++; if (got !== msgs[i]) begin errors++; $display("FAIL %s_msg%0d got %0h exp %0h", tag, i, got, msgs[i]); end
            w = (wire_q.size() > wb + 2 * i + 1) ? wire_q[wb + 2 * i + 1] : 6'bx;
            checks++; if (w !== word6(msgs[i], 1)) begin errors++; $display("FAIL %s_hiword%0d got %0h exp %0h", tag, i, w, word6(msgs[i], 1)); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] msgs[$];
        msgs = '{8'h00, 8'hFF, 8'h3C};
        run_msgs("b2b", msgs, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] msgs[$];
        for (int i = 0; i < 8; i++) msgs.push_back(8'($urandom));
        run_msgs("rnd", msgs, 1'b1);
    endtask

    task automatic test_reset_mid();
        int n, rb;
        logic [7:0] m, got;
        @(negedge clk); a_tx_valid = 1'b1; a_tx_msg = 8'($urandom);
        @(negedge clk); a_tx_valid = 1'b0;
        n = 0;
        while (a_req_out !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        rst = 1'b1;
        #1;
        checks++; if (a_req_out !== 1'b0) begin errors++; $display("FAIL rm_req got %0h exp 0", a_req_out); end
        checks++; if (a_tx_count !== 3'd0) begin errors++; $display("FAIL rm_count got %0d exp 0", a_tx_count); end
        checks++; if (a_data_out !== 6'h00) begin errors++; $display("FAIL rm_data got %0h exp 0", a_data_out); end
        checks++; if (b_rx_msg !== 8'h00) begin errors++; $display("FAIL rm_rxmsg got %0h exp 0", b_rx_msg); end
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        m = 8'($urandom);
        rb = b_rx_q.size();
        @(negedge clk); a_tx_valid = 1'b1; a_tx_msg = m;
        @(negedge clk); a_tx_valid = 1'b0;
        for (int i = 0; i < 300 && b_rx_q.size() < rb + 1; i++) @(negedge clk);
        repeat (20) @(negedge clk);
        got = (b_rx_q.size() > rb) ? b_rx_q[rb] : 8'bx;
        checks++; if (b_rx_q.size() - rb !== 1) begin errors++; $display("FAIL rm_pulses got %0d exp 1", b_rx_q.size() - rb); end
        checks++; if (got !== m) begin errors++; $display("FAIL rm_msg got %0h exp %0h", got, m); end
    endtask

    task automatic test_full_duplex();
        int cb, db, cw, dw;
        logic [7:0] gc, gd;
        cb = c_rx_q.size(); db = d_rx_q.size(); cw = c_words; dw = d_words;
        @(negedge clk);
        c_tx_valid = 1'b1; c_tx_msg = 8'h5A;
        d_tx_valid = 1'b1; d_tx_msg = 8'hC3;
        @(negedge clk); c_tx_valid = 1'b0; d_tx_valid = 1'b0;
        for (int i = 0; i < 300 && (c_rx_q.size() <= cb || d_rx_q.size() <= db); i++) @(negedge clk);
        repeat (20) @(negedge clk);
        gc = (c_rx_q.size() > cb) ? c_rx_q[cb] : 8'bx;
        gd = (d_rx_q.size() > db) ? d_rx_q[db] : 8'bx;
        checks++; if (d_rx_q.size() - db !== 1) begin errors++; $display("FAIL fd_d_pulses got %0d exp 1", d_rx_q.size() - db); end
        checks++; if (gd !== 8'h5A) begin errors++; $display("FAIL fd_d_msg got %0h exp 5a", gd); end
        checks++; if (c_rx_q.size() - cb !== 1) begin errors++; $display("FAIL fd_c_pulses got %0d exp 1", c_rx_q.size() - cb); end
        checks++; if (gc !== 8'hC3) begin errors++; $display("FAIL fd_c_msg got %0h exp c3", gc); end
        checks++; if (c_words - cw !== 1) begin errors++; $display("FAIL fd_c_words got %0d exp 1", c_words - cw); end
        checks++; if (d_words - dw !== 1) begin errors++; $display("FAIL fd_d_words got %0d exp 1", d_words - dw); end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; manual = 1'b0; tb_req_b = 1'b0; tb_data_b = '0;
        a_tx_valid = 1'b0; a_tx_msg = '0; b_tx_valid = 1'b0; b_tx_msg = '0;
        c_tx_valid = 1'b0; c_tx_msg = '0; d_tx_valid = 1'b0; d_tx_msg = '0;
        test_reset();
        test_loopback();
        test_timeout();
        test_back_to_back();
        test_resync();
        test_random();
        test_reset_mid();
        test_full_duplex();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
